miss_arbiter: RTL and testbench
===============================

Name: miss_arbiter

Overview:
- Shared backing-memory controller serving instruction-cache and data-cache line misses.
- Sits between fetch (imiss/iaddr), the data tag stage (dmiss/daddr) and the backing store.
- Arbitrates between the two requesters with data priority and a starvation guard, counts memory latency, and issues a single line read.
- Returns the 64-bit line on a shared stream bus with a one-cycle ifill or dfill pulse.

Parameters:
- MEM_LATENCY, 5: wait cycles between grant and memory read; legal range 1..255.
- STARVE_LIMIT, 4: consecutive data grants allowed while imiss is pending before instruction is forced; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- imiss  in  1  instruction line miss, level, held until ifill
- iaddr  in  32  instruction miss byte address
- dmiss  in  1  data line miss, level, held until dfill
- daddr  in  32  data miss byte address
- flush  in  1  jump redirect; cancels an outstanding instruction miss
- mem_rd_en  out  1  backing-store read strobe
- mem_line_addr  out  29  line address, addr[31:3]
- mem_rd_data  in  64  backing-store data, valid the cycle after mem_rd_en
- stream  out  64  line data to both caches
- ifill  out  1  instruction fill pulse
- dfill  out  1  data fill pulse
- busy  out  1  transaction in progress (state != IDLE)
- grant_d  out  1  current or last grant went to data

Behaviour:
- Reset values: state IDLE, mem_rd_en 0, mem_line_addr 0, stream 0, ifill 0, dfill 0, busy 0, grant_d 0. Latency counter, starvation counter and guard bit are all 0.
- Reset mid-transaction aborts it with no fill pulse; the memory read, if already issued, is discarded.
- States: IDLE, WAIT, READ, FILL.
- IDLE, guard bit set: ignore requests for exactly one cycle, then clear guard. This gives caches one cycle to drop the miss after the fill edge.
- IDLE, guard clear, arbitration:
  - dmiss only: grant D.
  - imiss only: grant I, unless flush is high that cycle; then no grant.
  - both high and starve_cnt == STARVE_LIMIT: grant I.
  - both high otherwise: grant D.
- On grant: latch the granted address[31:3] into mem_line_addr, set grant_d, load cnt = MEM_LATENCY-1, go to WAIT.
- Starvation counter (4 bits):
  - D grant while imiss high: increment, saturating at 15.
  - I grant, or D grant with imiss low: clear.
- WAIT:
  - cnt == 0: go to READ.
  - otherwise decrement cnt.
  - flush with grant I: abort to IDLE with guard clear and no memory read.
  - flush with grant D: ignored.
- READ: mem_rd_en = 1 for exactly this cycle; go to FILL.
- FILL:
  - stream <= mem_rd_data, registered; the pulse below is asserted in the following cycle, aligned with the new stream value.
  - Pulse dfill (grant D), or ifill (grant I and no flush seen since grant), for one cycle.
  - Go to IDLE with guard set.
- Flush arriving in READ or FILL with grant I: the read completes, stream updates, ifill is suppressed.
- Latency: request accepted in IDLE at cycle t. mem_rd_en at t+MEM_LATENCY+1; fill pulse and new stream at t+MEM_LATENCY+3. Next grant is possible at t+MEM_LATENCY+4.
- stream holds its last value between fills; ifill and dfill are never high together.
- Requests dropping while not in IDLE do not cancel the transaction, except flush as specified.
- mem_line_addr is stable from grant until the next grant.

Test Plan:
- Single D miss, daddr=0x0000_0148, MEM_LATENCY=5 -> mem_rd_en at t+6 with mem_line_addr=0x29; dfill at t+8 with stream equal to the memory word; ifill stays 0.
- Simultaneous imiss (iaddr=0x40) and dmiss (daddr=0x80) -> D served first (line 0x10); after the guard cycle I is granted (line 0x08); ifill is 9 cycles after dfill.
- dmiss held continuously with new addresses and imiss high, STARVE_LIMIT=4 -> four dfill pulses, then the fifth grant is I; ifill follows and starve_cnt returns to 0.
- imiss granted, flush pulsed in cycle 2 of WAIT -> no mem_rd_en, no ifill, busy drops the next cycle; a pending dmiss is then granted.
- imiss granted, flush during READ -> mem_rd_en seen, stream updates, ifill stays 0, guard cycle still honoured.
- reset asserted during WAIT of a D transaction -> next cycle all outputs 0 and state IDLE; no dfill ever appears for that transaction.

Source files
------------

// File: rtl/miss_arbiter.sv
// miss_arbiter: arbitrates I/D cache line misses onto one backing-store read, data priority with starvation guard
module miss_arbiter #(
  parameter int MEM_LATENCY  = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imiss,
  input  logic [31:0] iaddr,
  input  logic        dmiss,
  input  logic [31:0] daddr,
  input  logic        flush,
  output logic        mem_rd_en,
  output logic [28:0] mem_line_addr,
  input  logic [63:0] mem_rd_data,
  output logic [63:0] stream,
  output logic        ifill,
  output logic        dfill,
  output logic        busy,
  output logic        grant_d
);
  typedef enum logic [1:0] {IDLE, WAIT, READ, FILL} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  starve_cnt;
  logic        guard, flushed, gnt_i, gnt_d;
  always_comb begin
    gnt_d = dmiss && !(imiss && starve_cnt == 4'(STARVE_LIMIT));
    gnt_i = imiss && !gnt_d && (dmiss || !flush);
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      starve_cnt    <= '0;
      guard         <= 1'b0;
      flushed       <= 1'b0;
      mem_rd_en     <= 1'b0;
      mem_line_addr <= '0;
      stream        <= '0;
      ifill         <= 1'b0;
      dfill         <= 1'b0;
      grant_d       <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      ifill     <= 1'b0;
      dfill     <= 1'b0;
      case (state)
        IDLE: begin
          if (guard) guard <= 1'b0;
          else if (gnt_d || gnt_i) begin
            state         <= WAIT;
            grant_d       <= gnt_d;
            mem_line_addr <= gnt_d ? daddr[31:3] : iaddr[31:3];
            cnt           <= 8'(MEM_LATENCY - 1);
            flushed       <= 1'b0;
            starve_cnt    <= (gnt_d && imiss) ? starve_cnt + {3'b0, starve_cnt != 4'd15} : 4'd0;
          end
        end
        WAIT: begin
          // a redirect kills an instruction miss before any memory traffic
          if (flush && !grant_d) state <= IDLE;
          else if (cnt == 8'd0) begin
            state     <= READ;
            mem_rd_en <= 1'b1;
          end else cnt <= cnt - 8'd1;
        end
        READ: begin
          state   <= FILL;
          flushed <= flushed | flush;
        end
        FILL: begin
          stream <= mem_rd_data;
          dfill  <= grant_d;
          ifill  <= !grant_d && !flushed && !flush;
          state  <= IDLE;
          guard  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_miss_arbiter.sv
// tb_miss_arbiter: directed vector table plus hand-written corner sequences for miss_arbiter
module tb_miss_arbiter;
  localparam int LAT = 5;
  logic        clk = 0, reset = 1, imiss = 0, dmiss = 0, flush = 0;
  logic [31:0] iaddr = 0, daddr = 0;
  logic [63:0] mem_rd_data = 0;
  logic        mem_rd_en, ifill, dfill, busy, grant_d;
  logic [28:0] mem_line_addr;
  logic [63:0] stream;
  int asserts = 0, fails = 0, cyc = 0;
  int n_ifill = 0, n_dfill = 0, n_rd = 0, n_both = 0;

  miss_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .imiss(imiss), .iaddr(iaddr), .dmiss(dmiss), .daddr(daddr),
    .flush(flush), .mem_rd_en(mem_rd_en), .mem_line_addr(mem_line_addr), .mem_rd_data(mem_rd_data),
    .stream(stream), .ifill(ifill), .dfill(dfill), .busy(busy), .grant_d(grant_d));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ifill) n_ifill++;
    if (dfill) n_dfill++;
    if (mem_rd_en) n_rd++;
    if (ifill && dfill) n_both++;
  end

  typedef struct {
    logic        im, dm;
    logic [31:0] ia, da;
    logic [63:0] word;
    logic [28:0] line;
    logic        is_d;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_rd(output int n);
    n = 0;
    do begin step; n++; end while (!mem_rd_en && n < 50);
    if (!mem_rd_en) n = -1;
  endtask

  task automatic wait_fill(output int n);
    n = 0;
    do begin step; n++; end while (!(ifill || dfill) && n < 50);
    if (!(ifill || dfill)) n = -1;
  endtask

  initial begin
    int n, t_d, rd0, if0, df0;
    tbl[0] = '{1'b0, 1'b1, 32'h0, 32'h0000_0148, 64'h1111_2222_3333_4444, 29'h29, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 64'hA5A5_0000_FFFF_5A5A, 29'h08, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h0, 32'hFFFF_FFF8, 64'hDEAD_BEEF_0BAD_F00D, 29'h1FFF_FFFF, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 32'h1234_5678, 32'h0, 64'h0123_4567_89AB_CDEF, 29'h0246_8ACF, 1'b0};
    step; step;
    chk("rst_busy", busy, 0);
    chk("rst_rd", mem_rd_en, 0);
    chk("rst_addr", mem_line_addr, 0);
    chk("rst_stream", stream, 0);
    chk("rst_fill", {ifill, dfill}, 0);
    chk("rst_grant_d", grant_d, 0);
    reset = 0;
    step;

    foreach (tbl[i]) begin
      imiss = tbl[i].im; iaddr = tbl[i].ia;
      dmiss = tbl[i].dm; daddr = tbl[i].da;
      mem_rd_data = tbl[i].word;
      wait_rd(n);
      chk($sformatf("v%0d_rd_lat", i), n, LAT + 1);
      chk($sformatf("v%0d_line", i), mem_line_addr, tbl[i].line);
      chk($sformatf("v%0d_grant_d", i), grant_d, tbl[i].is_d);
      chk($sformatf("v%0d_busy", i), busy, 1);
      wait_fill(n);
      chk($sformatf("v%0d_fill_lat", i), n, 2);
      chk($sformatf("v%0d_fills", i), {ifill, dfill}, tbl[i].is_d ? 2'b01 : 2'b10);
      chk($sformatf("v%0d_stream", i), stream, tbl[i].word);
      imiss = 0; dmiss = 0;
      step;
      chk($sformatf("v%0d_pulse_end", i), {ifill, dfill}, 0);
    end

    // simultaneous misses: D first, I after the guard cycle
    imiss = 1; iaddr = 32'h40; dmiss = 1; daddr = 32'h80; mem_rd_data = 64'h5555;
    wait_rd(n);
    chk("both_first_line", mem_line_addr, 29'h10);
    wait_fill(n);
    chk("both_dfill", {ifill, dfill}, 2'b01);
    t_d = cyc;
    dmiss = 0; mem_rd_data = 64'h6666;
    wait_rd(n);
    chk("both_second_line", mem_line_addr, 29'h08);
    wait_fill(n);
    chk("both_ifill", {ifill, dfill}, 2'b10);
    chk("both_gap", cyc - t_d, 9);
    imiss = 0;
    step; step;

    // starvation guard: four D grants then I forced
    imiss = 1; iaddr = 32'h100; dmiss = 1;
    for (int k = 0; k < 4; k++) begin
      daddr = 32'h1000 + 32'(k * 8);
      wait_rd(n);
      chk($sformatf("starve%0d_line", k), mem_line_addr, 29'((32'h1000 + k * 8) >> 3));
      wait_fill(n);
      chk($sformatf("starve%0d_dfill", k), {ifill, dfill}, 2'b01);
    end
    wait_rd(n);
    chk("starve_i_line", mem_line_addr, 29'h20);
    chk("starve_i_grant", grant_d, 0);
    wait_fill(n);
    chk("starve_ifill", {ifill, dfill}, 2'b10);
    chk("starve_cnt_clr", dut.starve_cnt, 0);
    imiss = 0; dmiss = 0;
    step; step;

    // flush in second WAIT cycle cancels I; pending D then granted
    rd0 = n_rd; if0 = n_ifill;
    imiss = 1; iaddr = 32'h200;
    step;
    dmiss = 1; daddr = 32'h300;
    step;
    flush = 1; imiss = 0;
    step;
    flush = 0;
    chk("wflush_busy", busy, 0);
    chk("wflush_no_rd", n_rd - rd0, 0);
    wait_rd(n);
    chk("wflush_d_line", mem_line_addr, 29'h60);
    chk("wflush_d_grant", grant_d, 1);
    wait_fill(n);
    chk("wflush_dfill", {ifill, dfill}, 2'b01);
    chk("wflush_no_ifill", n_ifill - if0, 0);
    dmiss = 0;
    step; step;

    // flush during READ: read completes, stream updates, no ifill, guard honoured
    if0 = n_ifill;
    imiss = 1; iaddr = 32'h400; mem_rd_data = 64'hCAFE_F00D_1234_9876;
    wait_rd(n);
    chk("rflush_line", mem_line_addr, 29'h80);
    flush = 1; imiss = 0;
    step;
    flush = 0;
    step;
    chk("rflush_stream", stream, 64'hCAFE_F00D_1234_9876);
    chk("rflush_no_ifill", n_ifill - if0 + (ifill ? 1 : 0), 0);
    dmiss = 1; daddr = 32'h500;
    step;
    chk("rflush_guard", busy, 0);
    step;
    chk("rflush_after_guard", busy, 1);
    wait_fill(n);
    chk("rflush_dfill", dfill, 1);
    dmiss = 0;
    step; step;

    // reset during WAIT of a D transaction
    df0 = n_dfill; rd0 = n_rd;
    dmiss = 1; daddr = 32'h600;
    step; step;
    reset = 1;
    step;
    reset = 0; dmiss = 0;
    chk("mreset_state", dut.state, 0);
    chk("mreset_outs", {mem_rd_en, ifill, dfill, busy, grant_d}, 0);
    chk("mreset_addr", mem_line_addr, 0);
    chk("mreset_stream", stream, 0);
    repeat (15) step;
    chk("mreset_no_dfill", n_dfill - df0, 0);
    chk("mreset_no_rd", n_rd - rd0, 0);
    chk("never_both_fills", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
